// File: rtl/cpu_debug_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_responder
// Purpose  : Debug read responder for a single-cycle CPU. A display-side
//            requester asks for a register-file entry, a data-memory word,
//            the current PC or the current instruction. The responder fetches
//            the value through the CPU debug ports and returns it over a
//            valid/ready response channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_LAT     data-memory read latency in clk cycles (1..4)
// Ports
//   clk         clock, all state updates on the rising edge
//   resetn      synchronous active-low reset
//   req_valid   request present            req_ready   request accepted now
//   req_sel     00 RF, 01 MEM, 10 PC, 11 INST
//   req_addr    register index (RF) or byte address (MEM)
//   resp_valid  response present           resp_ready  response accepted
//   resp_data   response data              resp_err    request rejected
//   rf_addr     RF debug read address      rf_data     RF debug read data
//   mem_addr    MEM debug read address     mem_rd_en   MEM debug read strobe
//   mem_data    MEM read data, valid MEM_LAT cycles after the strobe cycle
//   cpu_pc      current PC                 cpu_inst    instruction at cpu_pc
//   cpu_busy    CPU step enable active; blocks new requests
//   txn_count   completed response handshakes (wraps)
// ============================================================================
module cpu_debug_responder #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  input  logic        cpu_busy,
  output logic [15:0] txn_count
);

  // Reject an out-of-range latency at elaboration time.
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("cpu_debug_responder: MEM_LAT must be in 1..4");
  end

  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RF_RD    = 3'd1,
    MEM_RD   = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] wait_cnt;
  logic       accept;
  logic       handshake;

  // Ready is combinational on cpu_busy so a request can be taken in the very
  // cycle the CPU stops stepping. Gating with resetn keeps it low in reset.
  assign req_ready = resetn && (state == IDLE) && !cpu_busy;
  assign accept    = req_valid && req_ready;
  assign handshake = resp_valid && resp_ready;

  // The request fields are latched straight into their consumers: the address
  // into rf_addr / mem_addr (which then drive the debug read ports), PC and
  // instruction into resp_data. The state itself records the selected target.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_err   <= 1'b0;
      rf_addr    <= 5'd0;
      mem_addr   <= 32'd0;
      mem_rd_en  <= 1'b0;
      txn_count  <= 16'd0;
      wait_cnt   <= 2'd0;
    end else begin
      // Strobe is only ever high for the single MEM_RD cycle.
      mem_rd_en <= 1'b0;

      if (handshake) begin
        txn_count <= txn_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            resp_err  <= 1'b0;
            resp_data <= 32'd0;
            case (req_sel)
              2'b00: begin
                if (|req_addr[31:5]) begin
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
                end else begin
                  rf_addr <= req_addr[4:0];
                  state   <= RF_RD;
                end
              end
              2'b01: begin
                if (|req_addr[1:0]) begin
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
                end else begin
                  mem_addr  <= req_addr;
                  mem_rd_en <= 1'b1;
                  state     <= MEM_RD;
                end
              end
              2'b10: begin
                resp_data  <= cpu_pc;
                resp_valid <= 1'b1;
                state      <= RESP;
              end
              default: begin
                resp_data  <= cpu_inst;
                resp_valid <= 1'b1;
                state      <= RESP;
              end
            endcase
          end
        end

        // rf_addr was registered at accept; the RF port reads asynchronously.
        RF_RD: begin
          resp_data  <= rf_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        // mem_rd_en is high during this cycle (registered at accept).
        MEM_RD: begin
          wait_cnt <= 2'd0;
          state    <= MEM_WAIT;
        end

        // Data becomes valid in the last of MEM_LAT wait cycles.
        MEM_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt   <= 2'd0;
            resp_data  <= mem_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        // Hold data/err stable until the display side takes the response.
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_debug_responder.md
CPU_DEBUG_RESPONDER -- requirements
Module: cpu_debug_responder

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in clk cycles; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 resetn  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  display-side request present.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_sel  input  2  request target: 00 register file, 01 data memory, 10 PC, 11 instruction.
REQ-007 req_addr  input  32  register index (sel 00) or byte address (sel 01); ignored for sel 10/11.
REQ-008 resp_valid  output  1  response present.
REQ-009 resp_ready  input  1  display side accepts the response.
REQ-010 resp_data  output  32  response data.
REQ-011 resp_err  output  1  request rejected; resp_data is 0 when set.
REQ-012 rf_addr  output  5  register-file debug read address, asynchronous read port.
REQ-013 rf_data  input  32  register-file debug read data.
REQ-014 mem_addr  output  32  data-memory debug read address.
REQ-015 mem_rd_en  output  1  data-memory debug read strobe.
REQ-016 mem_data  input  32  data-memory read data, valid MEM_LAT cycles after the mem_rd_en cycle.
REQ-017 cpu_pc  input  32  current CPU PC.
REQ-018 cpu_inst  input  32  instruction fetched at cpu_pc.
REQ-019 cpu_busy  input  1  CPU step clock enable active this cycle.
REQ-020 txn_count  output  16  number of completed response handshakes.

Function
REQ-021 The FSM states SHALL be IDLE, RF_RD, MEM_RD, MEM_WAIT and RESP.
REQ-022 req_ready SHALL be 1 only when the state is IDLE and cpu_busy=0; a request is accepted when req_valid and req_ready are both 1.
REQ-023 On accept, the block SHALL latch req_sel and req_addr.
REQ-024 Next state on accept:
- sel 00 with req_addr[31:5]!=0: RESP, err=1.
- sel 00 otherwise: RF_RD.
- sel 01 with req_addr[1:0]!=0: RESP, err=1.
- sel 01 otherwise: MEM_RD.
- sel 10: RESP with resp_data=cpu_pc sampled at accept.
- sel 11: RESP with resp_data=cpu_inst sampled at accept.
REQ-025 In RF_RD, the block SHALL drive rf_addr=latched addr[4:0] (registered at accept), capture rf_data into resp_data, and go to RESP.
REQ-026 In MEM_RD, the block SHALL drive mem_addr=latched addr and mem_rd_en=1 for exactly one cycle, then go to MEM_WAIT.
REQ-027 MEM_WAIT SHALL last MEM_LAT cycles, counted by a wait counter; on its last cycle the block SHALL capture mem_data into resp_data and go to RESP.
REQ-028 In RESP, resp_valid SHALL be 1, and resp_data/resp_err SHALL be held stable until resp_ready=1; on that handshake the next state SHALL be IDLE.
REQ-029 resp_valid SHALL be 0 in all states other than RESP.
REQ-030 Latency from the accept cycle N to the first resp_valid cycle:
- PC/INST/error: N+1.
- RF: N+2.
- MEM: N+2+MEM_LAT.
REQ-031 A new request SHALL NOT be accepted in the cycle of a response handshake; the earliest next accept is the following cycle.
REQ-032 cpu_busy asserting after accept SHALL NOT abort an in-flight request.
REQ-033 rf_addr and mem_addr SHALL hold their last driven value when idle.
REQ-034 mem_rd_en SHALL be 0 outside MEM_RD.
REQ-035 txn_count SHALL increment by 1 on each response handshake, including errors, and SHALL wrap from 0xFFFF to 0x0000.
REQ-036 resp_err SHALL be cleared when the next request is accepted.

Reset
REQ-037 When resetn=0 at a posedge, the block SHALL enter IDLE regardless of state, including mid-transaction, and discard any pending response.
REQ-038 Reset values SHALL be: resp_valid=0, resp_data=0, resp_err=0, rf_addr=0, mem_addr=0, mem_rd_en=0, txn_count=0, wait counter=0.
REQ-039 req_ready SHALL be 0 during any cycle in which resetn=0.

Verification
REQ-040 RF read: sel=00, addr=5, rf_data=0x1234_5678 -> rf_addr=5, resp_valid at N+2, resp_data=0x12345678, err=0, txn_count=1.
REQ-041 MEM read (MEM_LAT=1): sel=01, addr=0x10, mem_data=0xDEADBEEF -> mem_rd_en pulse at N+1 with mem_addr=0x10, resp at N+3 = 0xDEADBEEF; the same check SHALL be repeated with MEM_LAT=3 -> resp at N+5.
REQ-042 Errors: sel=01 addr=0x13, and sel=00 addr=0x20 -> each resp at N+1 with err=1, data=0, and no mem_rd_en pulse.
REQ-043 Backpressure: sel=10, cpu_pc=0x0000_0040, resp_ready=0 for 5 cycles -> resp_valid and data held at 0x40 for all 5 cycles; req_ready=0 throughout.
REQ-044 cpu_busy=1 with req_valid=1 -> no accept; after cpu_busy drops, accept in that cycle.
REQ-045 resetn=0 during MEM_WAIT -> next cycle IDLE with all outputs at reset values; force txn_count to 0xFFFF then one handshake -> txn_count=0.
